// File: rtl/cpu16_pkg.sv
// cpu16_pkg
// Shared definitions for the 16-bit CPU sequencer slice: instruction field
// positions, opcode and ALU function encodings, the sequencer state enum, the
// ALU select bundle, and small decode helpers used by the sequencer.
// No ports (package).

package cpu16_pkg;

  // Instruction word field positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 8;
  localparam int FN_MSB  = 7;
  localparam int FN_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Opcodes
  localparam logic [3:0] OP_ALU = 4'b0000;
  localparam logic [3:0] OP_LDI = 4'b0001;

  // ALU function field encodings
  localparam logic [3:0] FN_ADD = 4'b1010;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b1100;
  localparam logic [3:0] FN_OR  = 4'b1110;
  localparam logic [3:0] FN_XOR = 4'b1101;
  localparam logic [3:0] FN_NOT = 4'b1011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Function selects as driven to the external ALU
  typedef struct packed {
    logic sub;
    logic fas;
    logic andSel;
    logic orSel;
    logic xorSel;
    logic notSel;
  } sel_t;

  // An instruction is legal if it is an LDI, or an ALU op with a known function
  function automatic logic isLegal(input logic [15:0] ir);
    logic ok;
    ok = 1'b0;
    case (ir[OP_MSB:OP_LSB])
      OP_LDI: ok = 1'b1;
      OP_ALU: begin
        case (ir[FN_MSB:FN_LSB])
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOT: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Subtraction reuses the adder path, so SUB raises both FAS and SUB
  function automatic sel_t decodeSel(input logic [15:0] ir);
    sel_t s;
    s = '0;
    if (ir[OP_MSB:OP_LSB] == OP_ALU) begin
      case (ir[FN_MSB:FN_LSB])
        FN_ADD: s.fas = 1'b1;
        FN_SUB: begin
          s.fas = 1'b1;
          s.sub = 1'b1;
        end
        FN_AND: s.andSel = 1'b1;
        FN_OR:  s.orSel  = 1'b1;
        FN_XOR: s.xorSel = 1'b1;
        FN_NOT: s.notSel = 1'b1;
        default: s = '0;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/cpu16_regfile.sv
// cpu16_regfile
// 16 x DATA_W register file: asynchronous clear on reset, one synchronous
// write port, three combinational read ports (operand A, operand B, debug).
// Ports:
//   clk_i, rst_ni          clock (rising edge), async active-low clear
//   we_i, wa_i, wd_i       write enable / address / data
//   raA_i/rdA_o            operand A read
//   raB_i/rdB_o            operand B read
//   raDbg_i/rdDbg_o        debug read

module cpu16_regfile #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [3:0]        wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [3:0]        raA_i,
  output logic [DATA_W-1:0] rdA_o,
  input  logic [3:0]        raB_i,
  output logic [DATA_W-1:0] rdB_o,
  input  logic [3:0]        raDbg_i,
  output logic [DATA_W-1:0] rdDbg_o
);

  logic [DATA_W-1:0] rf_q [16];

  // Every entry is writable; there is no hardwired zero register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we_i) begin
      rf_q[wa_i] <= wd_i;
    end
  end

  // Reads return the stored value, so a register being written shows its old
  // contents until the write edge
  assign rdA_o   = rf_q[raA_i];
  assign rdB_o   = rf_q[raB_i];
  assign rdDbg_o = rf_q[raDbg_i];

endmodule

// File: rtl/cpu16_seq.sv
// cpu16_seq
// Four-state instruction sequencer (IDLE -> READ -> EXEC -> WRITE) that
// accepts one instruction per handshake, reads two operands from the register
// file into the ALU operand latches, drives the ALU function selects, captures
// the ALU result (or the LDI immediate) and writes it back.
// Ports:
//   CK, RST_N              clock (rising edge), async active-low reset
//   IR_VALID/IR_READY, IR  instruction handshake and word
//   ALU_A, ALU_B           operand latches to the external ALU
//   S_SUB..S_NOT           ALU function selects (only non-zero in EXEC)
//   ALU_R                  combinational ALU result
//   BUSY                   high outside IDLE
//   ILLEGAL                one-cycle pulse when an undefined instruction is dropped
//   DBG_N/DBG_D            debug register read

module cpu16_seq
  import cpu16_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter bit LDI_SEXT = 1'b1
) (
  input  logic              CK,
  input  logic              RST_N,
  input  logic              IR_VALID,
  output logic              IR_READY,
  input  logic [15:0]       IR,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic              S_SUB,
  output logic              S_FAS,
  output logic              S_AND,
  output logic              S_OR,
  output logic              S_XOR,
  output logic              S_NOT,
  input  logic [DATA_W-1:0] ALU_R,
  output logic              BUSY,
  output logic              ILLEGAL,
  input  logic [3:0]        DBG_N,
  output logic [DATA_W-1:0] DBG_D
);

  state_t            state_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] aluA_q;
  logic [DATA_W-1:0] aluB_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] res_d;
  sel_t              sel_q;
  logic              illegal_q;

  logic [DATA_W-1:0] rdA;
  logic [DATA_W-1:0] rdB;
  logic [DATA_W-1:0] ldiImm;

  cpu16_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk_i   (CK),
    .rst_ni  (RST_N),
    .we_i    (state_q == WRITE),
    .wa_i    (ir_q[RA_MSB:RA_LSB]),
    .wd_i    (res_q),
    .raA_i   (ir_q[RA_MSB:RA_LSB]),
    .rdA_o   (rdA),
    .raB_i   (ir_q[RB_MSB:RB_LSB]),
    .rdB_o   (rdB),
    .raDbg_i (DBG_N),
    .rdDbg_o (DBG_D)
  );

  always_comb begin
    if (LDI_SEXT) begin
      ldiImm = {{(DATA_W-8){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:IMM_LSB]};
    end else begin
      ldiImm = {{(DATA_W-8){1'b0}}, ir_q[IMM_MSB:IMM_LSB]};
    end
  end

  assign res_d = (ir_q[OP_MSB:OP_LSB] == OP_LDI) ? ldiImm : ALU_R;

  // Legality is decided at accept time so ILLEGAL comes straight from a flop
  // during READ. Selects and ILLEGAL default to 0 each cycle, which makes the
  // selects live only in EXEC and ILLEGAL a single-cycle pulse.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      aluA_q    <= '0;
      aluB_q    <= '0;
      res_q     <= '0;
      sel_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      sel_q     <= '0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (IR_VALID) begin
            ir_q      <= IR;
            illegal_q <= ~isLegal(IR);
            state_q   <= READ;
          end
        end
        READ: begin
          aluA_q <= rdA;
          aluB_q <= rdB;
          if (illegal_q) begin
            state_q <= IDLE;
          end else begin
            sel_q   <= decodeSel(ir_q);
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= res_d;
          state_q <= WRITE;
        end
        WRITE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IR_READY = (state_q == IDLE);
  assign BUSY     = (state_q != IDLE);
  assign ILLEGAL  = illegal_q;
  assign ALU_A    = aluA_q;
  assign ALU_B    = aluB_q;
  assign S_SUB    = sel_q.sub;
  assign S_FAS    = sel_q.fas;
  assign S_AND    = sel_q.andSel;
  assign S_OR     = sel_q.orSel;
  assign S_XOR    = sel_q.xorSel;
  assign S_NOT    = sel_q.notSel;

endmodule
